// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: presents one round key (0..10) per accepted
// advance, row-transposed onto q1..q4 for the single-round cipher stage.
module aes_key_expand #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [KW-1:0] key_in,
   input  logic          advance,
   output logic          valid,
   output logic          busy,
   output logic [3:0]    round,
   output logic          last,
   output logic [31:0]   q1,
   output logic [31:0]   q2,
   output logic [31:0]   q3,
   output logic [31:0]   q4
);

   // Handshake: q1..q4/round are a usable round key while valid=1; the
   // consumer takes it by raising advance, which steps to the next key at
   // the same edge. Without advance the presented key holds indefinitely.

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d, key_next;
   logic [3:0]   round_q, round_d;
   logic [31:0]  rot_w, sub_w, t_w, w0n, w1n, w2n, w3n;

   // w3 is the low column word; the chain w0'..w3' is the critical path.
   always_comb begin
      rot_w    = {key_q[23:0], key_q[31:24]};
      sub_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                  SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
      t_w      = sub_w ^ {rcon(round_q + 4'd1), 24'h000000};
      w0n      = key_q[127:96] ^ t_w;
      w1n      = key_q[95:64]  ^ w0n;
      w2n      = key_q[63:32]  ^ w1n;
      w3n      = key_q[31:0]   ^ w2n;
      key_next = {w0n, w1n, w2n, w3n};
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               round_d = 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (advance) begin
               if (round_q == LAST_ROUND) begin
                  state_d = IDLE;
               end else begin
                  key_d   = key_next;
                  round_d = round_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   assign valid = (state_q == RUN);
   assign busy  = (state_q == RUN);
   assign round = round_q;
   assign last  = (state_q == RUN) && (round_q == LAST_ROUND);

   // Byte transpose: key byte i sits at key_q[127-8i -: 8].
   assign q1 = {key_q[127:120], key_q[95:88], key_q[63:56], key_q[31:24]};
   assign q2 = {key_q[119:112], key_q[87:80], key_q[55:48], key_q[23:16]};
   assign q3 = {key_q[111:104], key_q[79:72], key_q[47:40], key_q[15:8]};
   assign q4 = {key_q[103:96],  key_q[71:64], key_q[39:32], key_q[7:0]};

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key schedule vectors,
// covering stalls, ignored start/advance, and asynchronous abort.
module tb_aes_key_expand;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         advance;
   logic         valid;
   logic         busy;
   logic [3:0]   round;
   logic         last;
   logic [31:0]  q1, q2, q3, q4;

   int n_checks;
   int n_errors;

   localparam logic [127:0] KEY_A    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   // Expected rows {q1,q2,q3,q4}
   localparam logic [127:0] A_R0  = 128'h0004080c_0105090d_02060a0e_03070b0f;
   localparam logic [127:0] A_R1  = 128'hd6d2dad6_aaafa6ab_74727876_fdfaf1fe;
   localparam logic [127:0] A_R10 = 128'h13e3f34d_1194072b_1d4aa730_7f178bc5;
   localparam logic [127:0] B_R0  = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
   localparam logic [127:0] B_R1  = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
   localparam logic [127:0] B_R10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;

   aes_key_expand #(.NR(10), .KW(128)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .key_in  (key_in),
      .advance (advance),
      .valid   (valid),
      .busy    (busy),
      .round   (round),
      .last    (last),
      .q1      (q1),
      .q2      (q2),
      .q3      (q3),
      .q4      (q4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_key(input string tag, input logic [127:0] exp);
      chk({tag, ".q1"}, q1, exp[127:96]);
      chk({tag, ".q2"}, q2, exp[95:64]);
      chk({tag, ".q3"}, q3, exp[63:32]);
      chk({tag, ".q4"}, q4, exp[31:0]);
   endtask

   task automatic chk_ctl(input string tag, input logic v, input logic b,
                          input logic [3:0] r, input logic l);
      chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
      chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
      chk({tag, ".round"}, {28'd0, round}, {28'd0, r});
      chk({tag, ".last"},  {31'd0, last},  {31'd0, l});
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      advance  = 1'b0;
      key_in   = '0;
      #1;
      chk_ctl("reset", 1'b0, 1'b0, 4'd0, 1'b0);
      chk_key("reset", 128'd0);
      step();
      step();
      rst_n = 1'b1;

      // advance alone in IDLE does nothing
      advance = 1'b1;
      step();
      chk_ctl("idle_adv", 1'b0, 1'b0, 4'd0, 1'b0);

      // Key A, start+advance together, advance held high
      start  = 1'b1;
      key_in = KEY_A;
      step();
      start  = 1'b0;
      key_in = '0;
      chk_ctl("a_r0", 1'b1, 1'b1, 4'd0, 1'b0);
      chk_key("a_r0", A_R0);
      step();
      chk_ctl("a_r1", 1'b1, 1'b1, 4'd1, 1'b0);
      chk_key("a_r1", A_R1);
      for (int r = 2; r <= 9; r++) begin
         step();
         chk("a_seq.round", {28'd0, round}, r);
         chk("a_seq.valid", {31'd0, valid}, 32'd1);
      end
      step();
      chk_ctl("a_r10", 1'b1, 1'b1, 4'd10, 1'b1);
      chk_key("a_r10", A_R10);
      step();
      chk_ctl("a_done", 1'b0, 1'b0, 4'd10, 1'b0);
      chk_key("a_done", A_R10);
      step();
      chk_ctl("a_post_adv", 1'b0, 1'b0, 4'd10, 1'b0);
      chk_key("a_post_adv", A_R10);

      // Key B with random stalls between accepted advances
      advance = 1'b0;
      start   = 1'b1;
      key_in  = KEY_B;
      step();
      start   = 1'b0;
      key_in  = '0;
      chk_ctl("b_r0", 1'b1, 1'b1, 4'd0, 1'b0);
      chk_key("b_r0", B_R0);
      for (int r = 1; r <= 10; r++) begin
         int n_stall;
         n_stall = $urandom_range(0, 5);
         for (int s = 0; s < n_stall; s++) begin
            step();
            chk("b_stall.round", {28'd0, round}, r - 1);
            chk("b_stall.valid", {31'd0, valid}, 32'd1);
            if (r == 1) chk_key("b_stall_r0", B_R0);
            if (r == 2) chk_key("b_stall_r1", B_R1);
         end
         advance = 1'b1;
         step();
         advance = 1'b0;
         chk("b_adv.round", {28'd0, round}, r);
         if (r == 1) chk_key("b_r1", B_R1);
      end
      chk_ctl("b_r10", 1'b1, 1'b1, 4'd10, 1'b1);
      chk_key("b_r10", B_R10);
      step();
      step();
      chk_ctl("b_r10_hold", 1'b1, 1'b1, 4'd10, 1'b1);
      chk_key("b_r10_hold", B_R10);
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk_ctl("b_done", 1'b0, 1'b0, 4'd10, 1'b0);

      // start pulsed mid-schedule with another key is ignored
      start  = 1'b1;
      key_in = KEY_A;
      step();
      start   = 1'b0;
      advance = 1'b1;
      for (int r = 1; r <= 4; r++) step();
      chk("ign.round4", {28'd0, round}, 32'd4);
      start  = 1'b1;
      key_in = KEY_B;
      step();
      start  = 1'b0;
      key_in = '0;
      chk("ign.round5", {28'd0, round}, 32'd5);
      for (int r = 6; r <= 10; r++) step();
      chk_ctl("ign_r10", 1'b1, 1'b1, 4'd10, 1'b1);
      chk_key("ign_r10", A_R10);
      step();
      chk_ctl("ign_done", 1'b0, 1'b0, 4'd10, 1'b0);

      // Asynchronous abort at round 6
      advance = 1'b1;
      start   = 1'b1;
      key_in  = KEY_B;
      step();
      start = 1'b0;
      for (int r = 1; r <= 6; r++) step();
      chk("abort.round6", {28'd0, round}, 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk_ctl("abort_async", 1'b0, 1'b0, 4'd0, 1'b0);
      chk_key("abort_async", 128'd0);
      #3;
      rst_n = 1'b1;
      step();
      step();
      chk_ctl("abort_adv", 1'b0, 1'b0, 4'd0, 1'b0);
      chk_key("abort_adv", 128'd0);

      // Fresh schedule after abort
      start  = 1'b1;
      key_in = KEY_A;
      step();
      start = 1'b0;
      chk_ctl("re_r0", 1'b1, 1'b1, 4'd0, 1'b0);
      chk_key("re_r0", A_R0);
      for (int r = 1; r <= 10; r++) begin
         step();
         chk("re_seq.round", {28'd0, round}, r);
         if (r == 1) chk_key("re_r1", A_R1);
      end
      chk_ctl("re_r10", 1'b1, 1'b1, 4'd10, 1'b1);
      chk_key("re_r10", A_R10);
      step();
      advance = 1'b0;
      chk_ctl("re_done", 1'b0, 1'b0, 4'd10, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
